// File: rtl/vga_pattern_sequencer.sv
// vga_pattern_sequencer
//   Chooses one of four monochrome test patterns and drives the registered pixel bit.
//   A debounced button press advances the pattern. When auto_en is set, the pattern
//   also advances every FRAMES_PER_PATTERN frames. The pattern only changes on a
//   newframe pulse, so a frame is never split between two patterns.
// Ports
//   clk, rst_n            : system clock; asynchronous active-low reset
//   x, y, valid           : pixel position from the timing generator; valid = visible area
//   newframe              : one-clock pulse at the start of each frame
//   btn_next              : raw button, active high, asynchronous to clk
//   auto_en               : level input; enables auto-advance
//   video                 : pixel bit, one clock after x/y/valid
//   pattern               : index of the displayed pattern
//   pending               : manual advance is waiting for the next newframe
module vga_pattern_sequencer #(
  parameter int H_ACTIVE           = 640,
  parameter int V_ACTIVE           = 480,
  parameter int FRAMES_PER_PATTERN = 60,
  parameter int DEBOUNCE_CYCLES    = 500000,
  parameter int LINE_SHIFT         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       valid,
  input  logic       newframe,
  input  logic       btn_next,
  input  logic       auto_en,
  output logic       video,
  output logic [1:0] pattern,
  output logic       pending
);

  localparam int          CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] FC_LAST = 16'(FRAMES_PER_PATTERN - 1);

  typedef enum logic {SHOW, PEND} state_t;

  // ---------------- button: synchroniser + debounce ----------------
  logic          sync0, sync1, db_lvl, press;
  logic [CW-1:0] db_cnt;

  // db_cnt counts consecutive clocks where the synchronised level differs from the
  // debounced level. Any clock where they agree restarts the count.
  assign press = sync1 && !db_lvl && (db_cnt == DB_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0  <= 1'b0;
      sync1  <= 1'b0;
      db_lvl <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync0 <= btn_next;
      sync1 <= sync0;
      if (sync1 == db_lvl) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_lvl <= sync1;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // ---------------- sequencer FSM ----------------
  state_t      state, state_nxt;
  logic [1:0]  pattern_nxt;
  logic [15:0] fcnt, fcnt_nxt;
  logic        auto_hit, advance;

  assign auto_hit = auto_en && newframe && (fcnt == FC_LAST);
  // A pending manual advance and an auto terminal on the same newframe give one step.
  assign advance  = newframe && ((state == PEND) || auto_hit);
  assign pending  = (state == PEND);

  always_comb begin
    state_nxt   = state;
    pattern_nxt = advance ? pattern + 2'd1 : pattern;
    fcnt_nxt    = fcnt;
    unique case (state)
      // A press on the same clock as newframe is still only recorded. The advance
      // waits for the following newframe.
      SHOW: if (press)    state_nxt = PEND;
      PEND: if (newframe) state_nxt = SHOW;
      default:            state_nxt = SHOW;
    endcase
    if (!auto_en)      fcnt_nxt = '0;
    else if (advance)  fcnt_nxt = '0;
    else if (newframe) fcnt_nxt = fcnt + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SHOW;
      pattern <= 2'd0;
      fcnt    <= '0;
    end else begin
      state   <= state_nxt;
      pattern <= pattern_nxt;
      fcnt    <= fcnt_nxt;
    end
  end

  // ---------------- pixel generation ----------------
  logic pix;

  always_comb begin
    pix = 1'b0;
    unique case (pattern)
      2'd0: pix = (x < 10'd2) || (x > 10'(H_ACTIVE - 2)) ||
                  (y < 10'd2) || (y > 10'(V_ACTIVE - 2));
      2'd1: pix = |x[LINE_SHIFT-1:0];
      2'd2: pix = 1'b1;
      2'd3: pix = x[5] ^ y[5];
      default: pix = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) video <= 1'b0;
    else        video <= valid & pix;
  end

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Testbench for vga_pattern_sequencer. Directed scenarios use hand-computed literal
// expectations. A random phase follows. A behavioural model is compared against the
// DUT on every falling clock edge.
module tb_vga_pattern_sequencer;

  localparam int H  = 640;
  localparam int V  = 480;
  localparam int FP = 3;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] x = '0, y = '0;
  logic       valid = 1'b0, newframe = 1'b0, btn_next = 1'b0, auto_en = 1'b0;
  logic       video, pending;
  logic [1:0] pattern;

  int n_chk = 0;
  int n_pass = 0;

  vga_pattern_sequencer #(
    .H_ACTIVE(H), .V_ACTIVE(V), .FRAMES_PER_PATTERN(FP),
    .DEBOUNCE_CYCLES(DB), .LINE_SHIFT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .valid(valid), .newframe(newframe),
    .btn_next(btn_next), .auto_en(auto_en), .video(video), .pattern(pattern),
    .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  function automatic int pix(input int p, input int px, input int py);
    case (p)
      0:       return (px < 2 || px > H - 2 || py < 2 || py > V - 2) ? 1 : 0;
      1:       return (px % 16 != 0) ? 1 : 0;
      2:       return 1;
      default: return ((px / 32) + (py / 32)) % 2;
    endcase
  endfunction

  int          m_pat, m_fc, m_video;
  bit          m_pend, m_db, m_bd1, m_bd2;
  bit [DB-1:0] m_win;   // last DB synchronised button samples

  always @(posedge clk or negedge rst_n) begin : model
    bit [DB-1:0] w;
    bit          nd, prs, adv;
    if (!rst_n) begin
      m_pat <= 0; m_fc <= 0; m_video <= 0; m_pend <= 1'b0;
      m_db <= 1'b0; m_bd1 <= 1'b0; m_bd2 <= 1'b0; m_win <= '0;
    end else begin
      // The debounced level flips once the last DB synchronised samples all disagree with it.
      w   = {m_win[DB-2:0], m_bd2};
      nd  = (w == {DB{~m_db}}) ? ~m_db : m_db;
      prs = nd && !m_db;
      adv = newframe && (m_pend || (auto_en && m_fc == FP - 1));
      m_win   <= w;
      m_db    <= nd;
      m_bd2   <= m_bd1;
      m_bd1   <= btn_next;
      m_video <= valid ? pix(m_pat, int'(x), int'(y)) : 0;
      m_pat   <= adv ? (m_pat + 1) % 4 : m_pat;
      m_pend  <= m_pend ? !newframe : prs;
      m_fc    <= (!auto_en || adv) ? 0 : (newframe ? m_fc + 1 : m_fc);
    end
  end

  always @(negedge clk) begin
    chk("model_video",   int'(video),   m_video);
    chk("model_pattern", int'(pattern), m_pat);
    chk("model_pending", int'(pending), int'(m_pend));
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic setpix(input int px, input int py, input bit v);
    x = 10'(px); y = 10'(py); valid = v;
  endtask

  task automatic pulse_nf();
    newframe = 1'b1; cyc(); newframe = 1'b0; cyc();
  endtask

  task automatic press_btn();
    btn_next = 1'b1; repeat (10) cyc();
    btn_next = 1'b0; repeat (8) cyc();
  endtask

  initial begin
    int hold;
    repeat (3) cyc();
    chk("reset_video",   int'(video),   0);
    chk("reset_pattern", int'(pattern), 0);
    chk("reset_pending", int'(pending), 0);
    rst_n = 1'b1;
    cyc();

    // pattern 0 border
    setpix(0, 100, 1);   cyc(); chk("border_x0",    int'(video), 1);
    setpix(320, 240, 1); cyc(); chk("border_mid",   int'(video), 0);
    setpix(639, 240, 1); cyc(); chk("border_x639",  int'(video), 1);
    setpix(0, 100, 0);   cyc(); chk("border_inval", int'(video), 0);

    // short glitch: 3 clocks high is not enough
    btn_next = 1'b1; repeat (3) cyc(); btn_next = 1'b0; repeat (8) cyc();
    chk("btn_short_pending", int'(pending), 0);
    // long press: pending rises on the 6th clock after the rise
    btn_next = 1'b1; repeat (5) cyc();
    chk("btn_pend_early", int'(pending), 0);
    cyc();
    chk("btn_pend_on", int'(pending), 1);
    repeat (4) cyc(); btn_next = 1'b0; repeat (8) cyc();
    chk("btn_hold_pend", int'(pending), 1);
    newframe = 1'b1; cyc(); newframe = 1'b0;
    chk("manual_adv_pattern", int'(pattern), 1);
    chk("manual_adv_pending", int'(pending), 0);
    repeat (4) cyc();
    chk("release_no_event", int'(pending), 0);

    // pattern 1 vertical lines
    setpix(16, 100, 1);  cyc(); chk("vlines_16",  int'(video), 0);
    setpix(17, 100, 1);  cyc(); chk("vlines_17",  int'(video), 1);
    setpix(639, 100, 1); cyc(); chk("vlines_639", int'(video), 1);

    // auto advance every 3 frames
    auto_en = 1'b1; cyc();
    pulse_nf(); pulse_nf();
    chk("auto_before_3rd", int'(pattern), 1);
    pulse_nf();
    chk("auto_after_3rd", int'(pattern), 2);
    repeat (3) pulse_nf();
    chk("auto_to_3", int'(pattern), 3);

    // pattern 3 checker
    setpix(32, 0, 1);  cyc(); chk("checker_32_0",  int'(video), 1);
    setpix(32, 32, 1); cyc(); chk("checker_32_32", int'(video), 0);

    repeat (12) pulse_nf();
    chk("auto_wrap_12", int'(pattern), 3);

    // PEND together with auto terminal gives a single advance
    pulse_nf(); pulse_nf();   // counter now 2
    chk("sim_pre_pattern", int'(pattern), 3);
    press_btn();
    chk("sim_pend", int'(pending), 1);
    pulse_nf();
    chk("sim_once_pattern", int'(pattern), 0);
    chk("sim_once_pending", int'(pending), 0);
    pulse_nf();
    chk("sim_counter_cleared", int'(pattern), 0);

    // press event on the same clock as newframe
    auto_en = 1'b0; cyc();
    btn_next = 1'b1; repeat (5) cyc();
    newframe = 1'b1; cyc(); newframe = 1'b0;
    chk("press_nf_pending", int'(pending), 1);
    chk("press_nf_pattern", int'(pattern), 0);
    repeat (4) cyc(); btn_next = 1'b0; repeat (8) cyc();
    pulse_nf();
    chk("press_nf_next_adv", int'(pattern), 1);

    // async reset in PEND with pattern 2
    press_btn(); pulse_nf(); press_btn();
    chk("pre_rst_pattern", int'(pattern), 2);
    chk("pre_rst_pending", int'(pending), 1);
    setpix(0, 0, 1); cyc();
    chk("pre_rst_video", int'(video), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pattern", int'(pattern), 0);
    chk("async_rst_pending", int'(pending), 0);
    chk("async_rst_video",   int'(video),   0);
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // random phase
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 400 == 0) auto_en = 1'($urandom_range(0, 1));
      if (hold == 0) begin
        btn_next = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 10);
      end
      hold--;
      case ($urandom_range(0, 3))
        0:       x = 10'($urandom_range(0, 3));
        1:       x = 10'($urandom_range(636, 639));
        default: x = 10'($urandom_range(0, 639));
      endcase
      y        = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(476, 479))
                                             : 10'($urandom_range(0, 479));
      valid    = ($urandom_range(0, 4) != 0);
      newframe = ($urandom_range(0, 19) == 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
